// File: rtl/control_seq_pkg.sv
// control_pkg: shared encodings and default constants for the microcode
// sequencer.
//   next_sel_e  - state-PLA next-select field (seq / dispatch / branch / reserved)
//   int_ack_e   - interrupt-entry acknowledge codes
//   *_STATE     - default sequencer state numbers
//   BRK_OPCODE  - opcode forced into the latch on interrupt entry
package control_pkg;

  typedef enum logic [1:0] {
    NS_SEQ    = 2'd0,
    NS_OPC    = 2'd1,
    NS_BRANCH = 2'd2,
    NS_RSVD   = 2'd3
  } next_sel_e;

  typedef enum logic [1:0] {
    INT_NONE = 2'b00,
    INT_IRQ  = 2'b01,
    INT_NMI  = 2'b10
  } int_ack_e;

  localparam int unsigned RESET_STATE            = 0;
  localparam int unsigned BRANCH_TAKEN_STATE     = 42;
  localparam int unsigned BRANCH_NOT_TAKEN_STATE = 45;
  localparam logic [7:0]  BRK_OPCODE             = 8'h00;

endpackage

// File: rtl/control_seq_int_ctrl.sv
// int_ctrl: interrupt recognition for the sequencer.
//   ph1, reset - clock (rising edge) and asynchronous active-low reset
//   rdy        - 1 = advance; 0 = stall (the NMI edge detector keeps running)
//   st_last    - last cycle of the current instruction
//   nmi_n      - non-maskable interrupt, falling-edge sensitive
//   irq_n      - interrupt request, level-low
//   i_flag     - IRQ-disable flag from the status register
//   int_ack    - registered entry code, updated only at st_last while rdy=1
module int_ctrl
  import control_pkg::*;
(
  input  logic       ph1,
  input  logic       reset,
  input  logic       rdy,
  input  logic       st_last,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic [1:0] int_ack
);

  logic     nmi_q;
  logic     nmi_pend;
  logic     nmi_edge;
  logic     nmi_take;
  int_ack_e int_sel;
  int_ack_e ack_q;

  // NMI outranks IRQ; IRQ is sampled live, never latched.
  always_comb begin
    int_sel = INT_NONE;
    if (nmi_pend) begin
      int_sel = INT_NMI;
    end else if (!irq_n && !i_flag) begin
      int_sel = INT_IRQ;
    end
  end

  assign nmi_edge = nmi_q & ~nmi_n;
  assign nmi_take = rdy & st_last & (int_sel == INT_NMI);

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
      ack_q    <= INT_NONE;
    end else begin
      nmi_q <= nmi_n;
      // A fresh edge arriving on the take cycle must not be lost.
      if (nmi_edge) begin
        nmi_pend <= 1'b1;
      end else if (nmi_take) begin
        nmi_pend <= 1'b0;
      end
      if (rdy && st_last) begin
        ack_q <= int_sel;
      end
    end
  end

  assign int_ack = ack_q;

endmodule

// File: rtl/mux2.sv
// mux2: W-bit two-input multiplexer primitive.
//   d0, d1 - data inputs
//   sel    - 0 selects d0, 1 selects d1
//   y      - selected data
module mux2 #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux3.sv
// mux3: W-bit three-input multiplexer primitive.
//   d0, d1, d2 - data inputs
//   sel        - 0 -> d0, 1 -> d1, 2 or 3 -> d2
//   y          - selected data
module mux3 #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = d2;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      default: y = d2;
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// control_seq: microcode sequencer for the hmc-6502 control unit.
// Holds the state register and opcode latch, selects the next state and
// resolves branches. State and opcode PLAs are external; their addresses
// (state, opcode) are driven here and their fields consumed in the same cycle.
//   ph1, reset   - clock (rising edge), asynchronous active-low reset
//   rdy          - 1 = advance; 0 = hold all sequencer state
//   data_in      - opcode bus from memory
//   p            - status register
//   nmi_n, irq_n - interrupt inputs
//   st_*         - state-PLA fields;  op_* - opcode-PLA fields
//   c_op_state, c_op_opcode - candidate opcode-specific controls
//   state, opcode - PLA addresses;  c_op - selected controls
//   first_cycle  - current cycle is the opcode fetch
//   int_ack      - 01 IRQ entry, 10 NMI entry, 00 none
//   cycle_cnt    - cycles since fetch, saturating at 7
//   illegal      - one-cycle pulse after a reserved next-select
module control_seq
  import control_pkg::*;
#(
  parameter int unsigned      STATE_W                = 8,
  parameter int unsigned      OPC_W                  = 8,
  parameter int unsigned      FLAGS_W                = 8,
  parameter int unsigned      OP_W                   = 14,
  parameter int unsigned      I_BIT                  = 2,
  parameter int unsigned      RESET_STATE            = control_pkg::RESET_STATE,
  parameter int unsigned      BRANCH_TAKEN_STATE     = control_pkg::BRANCH_TAKEN_STATE,
  parameter int unsigned      BRANCH_NOT_TAKEN_STATE = control_pkg::BRANCH_NOT_TAKEN_STATE,
  parameter logic [OPC_W-1:0] BRK_OPCODE             = OPC_W'(control_pkg::BRK_OPCODE)
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               rdy,
  input  logic [OPC_W-1:0]   data_in,
  input  logic [FLAGS_W-1:0] p,
  input  logic               nmi_n,
  input  logic               irq_n,
  input  logic               st_last,
  input  logic               st_op_sel,
  input  logic [1:0]         st_next_sel,
  input  logic [STATE_W-1:0] st_next,
  input  logic [STATE_W-1:0] op_next,
  input  logic [FLAGS_W-1:0] op_flags,
  input  logic               op_polarity,
  input  logic [OP_W-1:0]    c_op_state,
  input  logic [OP_W-1:0]    c_op_opcode,
  output logic [STATE_W-1:0] state,
  output logic [OPC_W-1:0]   opcode,
  output logic [OP_W-1:0]    c_op,
  output logic               first_cycle,
  output logic [1:0]         int_ack,
  output logic [2:0]         cycle_cnt,
  output logic               illegal
);

  localparam logic [STATE_W-1:0] RST_ST = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] BT_ST  = STATE_W'(BRANCH_TAKEN_STATE);
  localparam logic [STATE_W-1:0] BNT_ST = STATE_W'(BRANCH_NOT_TAKEN_STATE);

  logic               taken;
  logic               rsvd_sel;
  logic               force_brk;
  logic [STATE_W-1:0] branch_state;
  logic [STATE_W-1:0] sel_state;
  logic [STATE_W-1:0] next_state;
  logic [OPC_W-1:0]   opcode_src;
  logic [2:0]         cnt_next;

  assign taken     = op_polarity ^ (|(op_flags & p));
  assign rsvd_sel  = (st_next_sel == NS_RSVD);
  // int_ack was latched at the previous st_last, so it is stable across
  // the fetch cycle that follows and decides whether BRK replaces data_in.
  assign force_brk = (int_ack != INT_NONE);

  mux2 #(.W(OP_W)) u_cop_mux (
    .d0  (c_op_state),
    .d1  (c_op_opcode),
    .sel (st_op_sel),
    .y   (c_op)
  );

  mux2 #(.W(STATE_W)) u_branch_mux (
    .d0  (BNT_ST),
    .d1  (BT_ST),
    .sel (taken),
    .y   (branch_state)
  );

  mux3 #(.W(STATE_W)) u_next_mux (
    .d0  (st_next),
    .d1  (op_next),
    .d2  (branch_state),
    .sel (st_next_sel),
    .y   (sel_state)
  );

  // Reserved select traps back to the reset state.
  mux2 #(.W(STATE_W)) u_trap_mux (
    .d0  (sel_state),
    .d1  (RST_ST),
    .sel (rsvd_sel),
    .y   (next_state)
  );

  mux2 #(.W(OPC_W)) u_opc_mux (
    .d0  (data_in),
    .d1  (BRK_OPCODE),
    .sel (force_brk),
    .y   (opcode_src)
  );

  always_comb begin
    cnt_next = cycle_cnt;
    if (st_last) begin
      cnt_next = '0;
    end else if (cycle_cnt != 3'd7) begin
      cnt_next = cycle_cnt + 3'd1;
    end
  end

  int_ctrl u_int_ctrl (
    .ph1     (ph1),
    .reset   (reset),
    .rdy     (rdy),
    .st_last (st_last),
    .nmi_n   (nmi_n),
    .irq_n   (irq_n),
    .i_flag  (p[I_BIT]),
    .int_ack (int_ack)
  );

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state       <= RST_ST;
      opcode      <= '0;
      first_cycle <= 1'b1;
      cycle_cnt   <= '0;
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (rdy) begin
        state       <= next_state;
        first_cycle <= st_last;
        illegal     <= rsvd_sel;
        cycle_cnt   <= cnt_next;
        if (first_cycle) begin
          opcode <= opcode_src;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: self-checking bench for control_seq. Each row drives one
// cycle of PLA fields and pushes the expected post-edge outputs to a
// scoreboard queue; the entry is popped and compared after the edge.
module tb_control_seq;
  import control_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic [7:0] state;
    logic [7:0] opcode;
    logic [2:0] cnt;
    logic [1:0] ack;
    logic       ill;
    logic       first;
  } obs_t;

  typedef struct {
    logic       rdy;
    logic       last;
    logic [1:0] sel;
    logic [7:0] nxt;
    logic [7:0] opn;
    logic [7:0] din;
    logic [7:0] p;
    logic [7:0] flags;
    logic       pol;
    logic       nmi_n;
    logic       irq_n;
    obs_t       exp;
  } row_t;

  logic        ph1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  data_in = '0;
  logic [7:0]  p = '0;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic        st_last = 1'b0;
  logic        st_op_sel = 1'b0;
  logic [1:0]  st_next_sel = '0;
  logic [7:0]  st_next = '0;
  logic [7:0]  op_next = '0;
  logic [7:0]  op_flags = '0;
  logic        op_polarity = 1'b0;
  logic [13:0] c_op_state = '0;
  logic [13:0] c_op_opcode = '0;
  logic [7:0]  state;
  logic [7:0]  opcode;
  logic [13:0] c_op;
  logic        first_cycle;
  logic [1:0]  int_ack;
  logic [2:0]  cycle_cnt;
  logic        illegal;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t sb[$];

  always #5 ph1 = ~ph1;

  control_seq #(
    .STATE_W (8),
    .OPC_W   (8),
    .FLAGS_W (8),
    .OP_W    (14)
  ) dut (
    .ph1         (ph1),
    .reset       (rst_n),
    .rdy         (rdy),
    .data_in     (data_in),
    .p           (p),
    .nmi_n       (nmi_n),
    .irq_n       (irq_n),
    .st_last     (st_last),
    .st_op_sel   (st_op_sel),
    .st_next_sel (st_next_sel),
    .st_next     (st_next),
    .op_next     (op_next),
    .op_flags    (op_flags),
    .op_polarity (op_polarity),
    .c_op_state  (c_op_state),
    .c_op_opcode (c_op_opcode),
    .state       (state),
    .opcode      (opcode),
    .c_op        (c_op),
    .first_cycle (first_cycle),
    .int_ack     (int_ack),
    .cycle_cnt   (cycle_cnt),
    .illegal     (illegal)
  );

  function automatic obs_t obs();
    return '{state, opcode, cycle_cnt, int_ack, illegal, first_cycle};
  endfunction

  task automatic apply(input row_t r);
    rdy         = r.rdy;
    st_last     = r.last;
    st_next_sel = r.sel;
    st_next     = r.nxt;
    op_next     = r.opn;
    data_in     = r.din;
    p           = r.p;
    op_flags    = r.flags;
    op_polarity = r.pol;
    nmi_n       = r.nmi_n;
    irq_n       = r.irq_n;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset();
    obs_t e, got;
    @(posedge ph1); #1;
    sb.push_back('{8'h00, 8'h00, 3'd0, 2'b00, L, H});
    e = sb.pop_front(); got = obs(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset: got %p expected %p", got, e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_dispatch();
    obs_t e, got;
    row_t rows [3] = '{
      '{H, L, NS_OPC, 8'h00, 8'h03, 8'h69, 8'h00, 8'h00, L, H, H, '{8'h03, 8'h69, 3'd1, 2'b00, L, L}},
      '{H, L, NS_SEQ, 8'h04, 8'h00, 8'h11, 8'h00, 8'h00, L, H, H, '{8'h04, 8'h69, 3'd2, 2'b00, L, L}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, L, H, H, '{8'h00, 8'h69, 3'd0, 2'b00, L, H}}
    };
    foreach (rows[i]) begin
      @(negedge ph1); apply(rows[i]);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL dispatch[%0d]: got %p expected %p", i, got, e);
      end
    end
    c_op_state = 14'h0AAA; c_op_opcode = 14'h1555; st_op_sel = 1'b1; #1;
    vectors++;
    if (c_op !== 14'h1555) begin
      miscompares++;
      $display("FAIL c_op_opcode_sel: got %h expected %h", c_op, 14'h1555);
    end
    st_op_sel = 1'b0; #1;
    vectors++;
    if (c_op !== 14'h0AAA) begin
      miscompares++;
      $display("FAIL c_op_state_sel: got %h expected %h", c_op, 14'h0AAA);
    end
  endtask

  task automatic test_branch();
    obs_t e, got;
    row_t rows [4] = '{
      '{H, H, NS_BRANCH, 8'h00, 8'h00, 8'h90, 8'h02, 8'h02, L, H, H, '{8'd42, 8'h90, 3'd0, 2'b00, L, H}},
      '{H, H, NS_BRANCH, 8'h00, 8'h00, 8'hB0, 8'h02, 8'h02, H, H, H, '{8'd45, 8'hB0, 3'd0, 2'b00, L, H}},
      '{H, H, NS_BRANCH, 8'h00, 8'h00, 8'hD0, 8'h01, 8'h02, L, H, H, '{8'd45, 8'hD0, 3'd0, 2'b00, L, H}},
      '{H, H, NS_BRANCH, 8'h00, 8'h00, 8'hF0, 8'h01, 8'h02, H, H, H, '{8'd42, 8'hF0, 3'd0, 2'b00, L, H}}
    };
    foreach (rows[i]) begin
      @(negedge ph1); apply(rows[i]);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %p expected %p", i, got, e);
      end
    end
  endtask

  task automatic test_stall_nmi();
    obs_t e, got;
    row_t rows [8] = '{
      '{H, L, NS_SEQ,  8'h0A, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h0A, 8'hEA, 3'd1, 2'b00, L, L}},
      '{H, L, NS_SEQ,  8'h0B, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h0B, 8'hEA, 3'd2, 2'b00, L, L}},
      '{L, L, NS_SEQ,  8'h63, 8'h00, 8'hEA, 8'h00, 8'h00, L, L, H, '{8'h0B, 8'hEA, 3'd2, 2'b00, L, L}},
      '{L, H, NS_RSVD, 8'h63, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h0B, 8'hEA, 3'd2, 2'b00, L, L}},
      '{L, L, NS_SEQ,  8'h63, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h0B, 8'hEA, 3'd2, 2'b00, L, L}},
      '{H, H, NS_SEQ,  8'h00, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h00, 8'hEA, 3'd0, 2'b10, L, H}},
      '{H, L, NS_SEQ,  8'h05, 8'h00, 8'h4C, 8'h00, 8'h00, L, H, H, '{8'h05, 8'h00, 3'd1, 2'b10, L, L}},
      '{H, H, NS_SEQ,  8'h00, 8'h00, 8'h4C, 8'h00, 8'h00, L, H, H, '{8'h00, 8'h00, 3'd0, 2'b00, L, H}}
    };
    foreach (rows[i]) begin
      @(negedge ph1); apply(rows[i]);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL stall_nmi[%0d]: got %p expected %p", i, got, e);
      end
    end
  endtask

  task automatic test_irq();
    obs_t e, got;
    row_t rows [8] = '{
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hA9, 8'h04, 8'h00, L, H, L, '{8'h00, 8'hA9, 3'd0, 2'b00, L, H}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, L, H, L, '{8'h00, 8'hA5, 3'd0, 2'b01, L, H}},
      '{H, L, NS_SEQ, 8'h07, 8'h00, 8'hC9, 8'h00, 8'h00, L, H, L, '{8'h07, 8'h00, 3'd1, 2'b01, L, L}},
      '{H, L, NS_SEQ, 8'h08, 8'h00, 8'hC9, 8'h00, 8'h00, L, L, L, '{8'h08, 8'h00, 3'd2, 2'b01, L, L}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hC9, 8'h00, 8'h00, L, H, L, '{8'h00, 8'h00, 3'd0, 2'b10, L, H}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hC9, 8'h00, 8'h00, L, H, L, '{8'h00, 8'h00, 3'd0, 2'b01, L, H}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hE8, 8'h00, 8'h00, L, H, H, '{8'h00, 8'h00, 3'd0, 2'b00, L, H}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hE8, 8'h00, 8'h00, L, H, H, '{8'h00, 8'hE8, 3'd0, 2'b00, L, H}}
    };
    foreach (rows[i]) begin
      @(negedge ph1); apply(rows[i]);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL irq[%0d]: got %p expected %p", i, got, e);
      end
    end
  endtask

  task automatic test_nmi_set_wins();
    obs_t e, got;
    row_t rows [5] = '{
      '{H, L, NS_SEQ, 8'h30, 8'h00, 8'h20, 8'h00, 8'h00, L, L, H, '{8'h30, 8'h20, 3'd1, 2'b00, L, L}},
      '{H, L, NS_SEQ, 8'h31, 8'h00, 8'h20, 8'h00, 8'h00, L, H, H, '{8'h31, 8'h20, 3'd2, 2'b00, L, L}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, L, L, H, '{8'h00, 8'h20, 3'd0, 2'b10, L, H}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00, L, H, H, '{8'h00, 8'h00, 3'd0, 2'b10, L, H}},
      '{H, H, NS_SEQ, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00, L, H, H, '{8'h00, 8'h00, 3'd0, 2'b00, L, H}}
    };
    foreach (rows[i]) begin
      @(negedge ph1); apply(rows[i]);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL nmi_set_wins[%0d]: got %p expected %p", i, got, e);
      end
    end
  endtask

  task automatic test_illegal();
    obs_t e, got;
    row_t rows [2] = '{
      '{H, L, NS_RSVD, 8'h33, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h00, 8'hEA, 3'd1, 2'b00, H, L}},
      '{H, L, NS_SEQ,  8'h06, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h06, 8'hEA, 3'd2, 2'b00, L, L}}
    };
    foreach (rows[i]) begin
      @(negedge ph1); apply(rows[i]);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got %p expected %p", i, got, e);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, got;
    row_t r;
    r = '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h00, 8'hEA, 3'd0, 2'b00, L, H}};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        r.last = L;
        r.nxt  = 8'h20 + 8'(i - 1);
        r.exp  = '{8'h20 + 8'(i - 1), 8'hEA, (i > 7) ? 3'd7 : 3'(i), 2'b00, L, L};
      end
      @(negedge ph1); apply(r);
      @(posedge ph1); #1;
      e = sb.pop_front(); got = obs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got %p expected %p", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, got;
    row_t r;
    // Reach state 25 with a fresh NMI edge pending.
    r = '{H, L, NS_SEQ, 8'd25, 8'h00, 8'hEA, 8'h00, 8'h00, L, L, H, '{8'd25, 8'hEA, 3'd7, 2'b00, L, L}};
    @(negedge ph1); apply(r);
    @(posedge ph1); #1;
    e = sb.pop_front(); got = obs(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_reset_pre: got %p expected %p", got, e);
    end
    @(negedge ph1); #2;
    nmi_n = 1'b1;
    rst_n = 1'b0;
    sb.push_back('{8'h00, 8'h00, 3'd0, 2'b00, L, H});
    #1;
    e = sb.pop_front(); got = obs(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_reset_noclk: got %p expected %p", got, e);
    end
    @(posedge ph1); #1;
    rst_n = 1'b1;
    // Pending NMI must have been discarded by reset.
    r = '{H, H, NS_SEQ, 8'h00, 8'h00, 8'hEA, 8'h00, 8'h00, L, H, H, '{8'h00, 8'hEA, 3'd0, 2'b00, L, H}};
    @(negedge ph1); apply(r);
    @(posedge ph1); #1;
    e = sb.pop_front(); got = obs(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_reset_post: got %p expected %p", got, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dispatch();
    test_branch();
    test_stall_nmi();
    test_irq();
    test_nmi_set_wins();
    test_illegal();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
